// File: rtl/ysyx_220053_exu_mc.sv
// Multi-cycle execute unit with a private register file: single-cycle ALU plus an
// iterative shift-add multiplier, valid/ready on both sides, writeback on output handshake.
module ysyx_220053_exu_mc #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wen,
    input  logic              alusrcb,
    input  logic [XLEN-1:0]   imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]   out_res,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);
    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned CNT_W = SHW + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(2);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(3);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(4);
    localparam logic [OP_W-1:0] OpSll  = OP_W'(5);
    localparam logic [OP_W-1:0] OpSrl  = OP_W'(6);
    localparam logic [OP_W-1:0] OpSra  = OP_W'(7);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(8);
    localparam logic [OP_W-1:0] OpSltu = OP_W'(9);
    localparam logic [OP_W-1:0] OpMul  = OP_W'(10);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e              state_q;
    logic [XLEN-1:0]     regs_q [NREG];
    logic [XLEN-1:0]     a_q, b_q, acc_q, res_q;
    logic [ADDR_W-1:0]   rd_q;
    logic                wen_q, valid_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [XLEN-1:0]     op_a, op_b, alu_res, mul_acc;
    logic [SHW-1:0]      shamt;

    always_comb begin
        op_a     = (rs1 == '0) ? '0 : regs_q[rs1];
        op_b     = alusrcb ? imm : ((rs2 == '0) ? '0 : regs_q[rs2]);
        dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
        shamt    = op_b[SHW-1:0];
        mul_acc  = b_q[0] ? acc_q + a_q : acc_q;
    end

    // Undefined opcodes (including MUL, which never takes this path) yield zero.
    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpSll:   alu_res = op_a << shamt;
            OpSrl:   alu_res = op_a >> shamt;
            OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rd_q  <= rd;
                        wen_q <= wen;
                        if (op == OpMul) begin
                            a_q     <= op_a;
                            b_q     <= op_b;
                            acc_q   <= '0;
                            cnt_q   <= CNT_W'(XLEN);
                            state_q <= StMul;
                        end else begin
                            res_q   <= alu_res;
                            valid_q <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StMul: begin
                    acc_q <= mul_acc;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last bit: publish the final partial sum directly.
                    if (cnt_q == CNT_W'(1)) begin
                        res_q   <= mul_acc;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        if (wen_q && rd_q != '0) regs_q[rd_q] <= res_q;
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = valid_q;
    assign out_res   = res_q;
    assign out_rd    = rd_q;
endmodule

// File: tb/tb_ysyx_220053_exu_mc.sv
// Directed bench for ysyx_220053_exu_mc at XLEN=64: ALU ops, multiplier latency,
// backpressure, x0/wen handling and asynchronous reset during a multiply.
module tb_ysyx_220053_exu_mc;
    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        wen, alusrcb;
    logic [63:0] imm;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [63:0] out_res;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    int checks = 0;
    int errors = 0;

    ysyx_220053_exu_mc #(.XLEN(64), .ADDR_W(5), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .rd(rd), .wen(wen), .alusrcb(alusrcb), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_res(out_res),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, wait for its result (bounded), then complete the output handshake.
    // Returns at posedge+1 of the handshake edge; lat is -1 on timeout.
    task automatic do_op(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic w, input logic s,
                         input logic [63:0] im, output int lat, output logic [63:0] res,
                         output logic [4:0] ord, output int ready_hi);
        op = o; rs1 = a; rs2 = b; rd = d; wen = w; alusrcb = s; imm = im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        ready_hi = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_hi++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_res;
        ord = out_rd;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        rd = '0; wen = 1'b0; alusrcb = 1'b0; imm = '0; dbg_addr = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_res !== 64'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL reset_out got res %h rd %0d want 0 0", out_res, out_rd); end
        checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL reset_x1 got %h want 0", dbg_data); end
    endtask

    task automatic test_alu;
        int lat, rh; logic [63:0] r; logic [4:0] orr;
        do_op(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 64'd5, lat, r, orr, rh);
        dbg_addr = 5'd1; #1;
        checks++; if (lat !== 1 || r !== 64'd5 || orr !== 5'd1) begin errors++; $display("FAIL add_imm got lat %0d res %h rd %0d want 1 5 1", lat, r, orr); end
        checks++; if (dbg_data !== 64'd5) begin errors++; $display("FAIL add_wb_x1 got %h want 5", dbg_data); end
        do_op(4'd1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 64'd0, lat, r, orr, rh);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL sub got %h want fffffffffffffffb", r); end
        do_op(4'd7, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 64'd1, lat, r, orr, rh);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sra got %h want fffffffffffffffd", r); end
        do_op(4'd6, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 64'd65, lat, r, orr, rh);
        checks++; if (r !== 64'h7FFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL srl65 got %h want 7ffffffffffffffd", r); end
        do_op(4'd8, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 64'd0, lat, r, orr, rh);
        checks++; if (r !== 64'd1) begin errors++; $display("FAIL slt got %h want 1", r); end
        do_op(4'd9, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 64'd0, lat, r, orr, rh);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL sltu got %h want 0", r); end
        do_op(4'd2, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 64'd6, lat, r, orr, rh);
        checks++; if (r !== 64'd4) begin errors++; $display("FAIL and got %h want 4", r); end
        do_op(4'd3, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 64'd6, lat, r, orr, rh);
        checks++; if (r !== 64'd7) begin errors++; $display("FAIL or got %h want 7", r); end
        do_op(4'd4, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 64'd6, lat, r, orr, rh);
        checks++; if (r !== 64'd3) begin errors++; $display("FAIL xor got %h want 3", r); end
        do_op(4'd5, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 64'd4, lat, r, orr, rh);
        checks++; if (r !== 64'h50) begin errors++; $display("FAIL sll got %h want 50", r); end
        // Undefined opcode overwrites a previously non-zero register with 0.
        do_op(4'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 64'd9, lat, r, orr, rh);
        do_op(4'd11, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 64'd9, lat, r, orr, rh);
        dbg_addr = 5'd5; #1;
        checks++; if (lat !== 1 || r !== 64'd0 || dbg_data !== 64'd0) begin errors++; $display("FAIL undef_op got lat %0d res %h x5 %h want 1 0 0", lat, r, dbg_data); end
    endtask

    task automatic test_mul;
        int lat, rh; logic [63:0] r; logic [4:0] orr;
        do_op(4'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, lat, r, orr, rh);
        do_op(4'd10, 5'd6, 5'd6, 5'd12, 1'b1, 1'b0, 64'd0, lat, r, orr, rh);
        checks++; if (lat !== 65) begin errors++; $display("FAIL mul_latency got %0d want 65", lat); end
        checks++; if (r !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_res got %h want fffffffe00000001", r); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL mul_in_ready got %0d high cycles want 0", rh); end
        dbg_addr = 5'd12; #1;
        checks++; if (dbg_data !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_wb got %h want fffffffe00000001", dbg_data); end
        do_op(4'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 64'h8000_0000_0000_0000, lat, r, orr, rh);
        do_op(4'd10, 5'd7, 5'd0, 5'd13, 1'b1, 1'b1, 64'd2, lat, r, orr, rh);
        checks++; if (lat !== 65 || r !== 64'd0) begin errors++; $display("FAIL mul_ovf got lat %0d res %h want 65 0", lat, r); end
        do_op(4'd10, 5'd1, 5'd0, 5'd13, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, lat, r, orr, rh);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mul_neg got %h want fffffffffffffff1", r); end
    endtask

    task automatic test_backpressure;
        int n;
        op = 4'd0; rs1 = 5'd0; rd = 5'd8; wen = 1'b1; alusrcb = 1'b1; imm = 64'h1234;
        dbg_addr = 5'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_res !== 64'h1234 || out_rd !== 5'd8 ||
                in_ready !== 1'b0 || dbg_data !== 64'd0) begin
                errors++;
                $display("FAIL bp_hold_%0d got v %b res %h rd %0d rdy %b x8 %h want 1 1234 8 0 0",
                         i, out_valid, out_res, out_rd, in_ready, dbg_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (dbg_data !== 64'h1234 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got x8 %h v %b rdy %b want 1234 0 1", dbg_data, out_valid, in_ready); end
    endtask

    task automatic test_x0_wen;
        int lat, rh; logic [63:0] r; logic [4:0] orr;
        do_op(4'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 64'd7, lat, r, orr, rh);
        dbg_addr = 5'd0; #1;
        checks++; if (r !== 64'd7 || dbg_data !== 64'd0) begin errors++; $display("FAIL x0_write got res %h x0 %h want 7 0", r, dbg_data); end
        do_op(4'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 64'd11, lat, r, orr, rh);
        dbg_addr = 5'd3; #1;
        checks++; if (r !== 64'd11 || dbg_data !== 64'd0) begin errors++; $display("FAIL wen0 got res %h x3 %h want 11 0", r, dbg_data); end
    endtask

    task automatic test_back_to_back;
        int lat, rh; logic [63:0] r; logic [4:0] orr;
        do_op(4'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 64'd100, lat, r, orr, rh);
        do_op(4'd0, 5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 64'd1, lat, r, orr, rh);
        checks++; if (r !== 64'd101 || lat !== 1) begin errors++; $display("FAIL raw_b2b got res %h lat %0d want 101 1", r, lat); end
    endtask

    task automatic test_mul_reset;
        int lat, rh; logic [63:0] r; logic [4:0] orr;
        op = 4'd10; rs1 = 5'd6; rs2 = 5'd6; rd = 5'd14; wen = 1'b1; alusrcb = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy got in_ready %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        dbg_addr = 5'd6; #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_data !== 64'd0) begin errors++; $display("FAIL async_reset got v %b rdy %b x6 %h want 0 1 0", out_valid, in_ready, dbg_data); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 64'd3, lat, r, orr, rh);
        dbg_addr = 5'd14; #1;
        checks++; if (lat !== 1 || r !== 64'd3 || dbg_data !== 64'd0) begin errors++; $display("FAIL post_reset_add got lat %0d res %h x14 %h want 1 3 0", lat, r, dbg_data); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_backpressure();
        test_x0_wen();
        test_back_to_back();
        test_mul_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
